flasher_scheduler: RTL and testbench

Round-robin scheduler that shares one `Bound_Flasher` LED bank between `NREQ` requesters. It grants one requester at a time and starts a flasher sequence by pulsing `flick`. It then watches the flasher's `LED` bus to detect when the sequence has completed. A watchdog resets the flasher through its active-low reset if a sequence hangs. The block sits between the request sources and the flasher, and is the only driver of the flasher's `flick` and `reset` inputs.

---
 rtl/flasher_scheduler.sv | 153 +++++++++++++++
 tb/tb_flasher_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flasher_scheduler.sv
// Round-robin owner of one Bound_Flasher bank: kicks a sequence,
// watches LED for completion, and resets the flasher on a hang.
module flasher_scheduler #(
  parameter int NREQ       = 4,
  parameter int QUIET      = 2,
  parameter int MAX_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [15:0]     LED,
  output logic [NREQ-1:0] grant,
  output logic            flick,
  output logic            flasher_rst_n,
  output logic            busy,
  output logic            done,
  output logic            abort
);

  localparam int IW = $clog2(NREQ);
  localparam int WW = $clog2(MAX_CYCLES + 1);
  localparam int QW = $clog2(QUIET + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ABORT
  } state_t;

  state_t state, state_d;

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   pick;
  logic            found;
  int unsigned     j;
  logic [WW-1:0]   wdog;
  logic [QW-1:0]   zcnt;
  logic            led_zero;
  logic            wd_hit;
  logic            quiet_hit;

  logic [NREQ-1:0] grant_d;
  logic            flick_d;
  logic            frst_d;
  logic            busy_d;
  logic            done_d;
  logic            abort_d;

  assign led_zero  = (LED == 16'd0);
  assign wd_hit    = (wdog == WW'(MAX_CYCLES));
  assign quiet_hit = led_zero
                   && (zcnt == QW'(QUIET - 1));

  // first asserted request at or after ptr
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  // watchdog is checked before completion
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (found) state_d = S_KICK;
      S_KICK:  state_d = S_RUN;
      S_RUN: begin
        if (wd_hit)         state_d = S_ABORT;
        else if (!led_zero) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (wd_hit)         state_d = S_ABORT;
        else if (quiet_hit) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant;
    if (state_d == S_IDLE)
      grant_d = '0;
    else if (state == S_IDLE)
      grant_d = NREQ'(1) << pick;
    flick_d = (state_d == S_KICK);
    frst_d  = (state_d != S_ABORT);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    abort_d = (state_d == S_ABORT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant         <= '0;
      flick         <= 1'b0;
      flasher_rst_n <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      abort         <= 1'b0;
    end else begin
      grant         <= grant_d;
      flick         <= flick_d;
      flasher_rst_n <= frst_d;
      busy          <= busy_d;
      done          <= done_d;
      abort         <= abort_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr  <= '0;
      gidx <= '0;
      wdog <= '0;
      zcnt <= '0;
    end else begin
      if (state == S_IDLE && found)
        gidx <= pick;
      if (state == S_KICK)
        ptr <= (gidx == IW'(NREQ - 1))
             ? '0 : gidx + 1'b1;
      if (state == S_IDLE)
        wdog <= '0;
      else if (!wd_hit)
        wdog <= wdog + 1'b1;
      if (state != S_DRAIN)
        zcnt <= '0;
      else if (led_zero)
        zcnt <= zcnt + 1'b1;
      else
        zcnt <= '0;
    end
  end

endmodule

// File: tb/tb_flasher_scheduler.sv
// Scoreboard bench for flasher_scheduler: scheduled stimulus,
// session-level reference model, event monitor.
module tb_flasher_scheduler;

  localparam int NREQ  = 4;
  localparam int QUIET = 2;
  localparam int MAXC  = 255;
  localparam int LEN   = MAXC + 8;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req   = '0;
  logic [15:0] LED   = '0;
  logic [3:0]  grant;
  logic        flick;
  logic        flasher_rst_n;
  logic        busy;
  logic        done;
  logic        abort;

  flasher_scheduler #(
    .NREQ(NREQ),
    .QUIET(QUIET),
    .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .LED(LED),
    .grant(grant),
    .flick(flick),
    .flasher_rst_n(flasher_rst_n),
    .busy(busy),
    .done(done),
    .abort(abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  bit live = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) live <= reset;

  int tests = 0;
  int fails = 0;

  // kind: 0 kick, 1 done, 2 abort
  typedef struct {
    int         kind;
    int         at;
    logic [3:0] g;
  } ev_t;

  ev_t exp_q[$];
  bit  chk_rel = 1'b0;
  int  ptr_m = 0;
  logic [15:0] L [LEN];

  task automatic check(string name, int act, int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, act, want, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    int  k;
    ev_t e;
    if (reset && live) begin
      if (chk_rel) begin
        check("release_grant", int'(grant), 0);
        check("release_busy", int'(busy), 0);
        chk_rel = 1'b0;
      end
      check("rst_n_vs_abort", int'(flasher_rst_n),
            int'(!abort));
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        e = exp_q.pop_front();
        check("missed_event", -1, e.kind);
      end
      if (flick || done || abort) begin
        k = flick ? 0 : (done ? 1 : 2);
        if (exp_q.size() == 0) begin
          check("unexpected_event", k, -1);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", k, e.kind);
          check("event_cycle", cyc, e.at);
          check("event_grant", int'(grant), int'(e.g));
          if (k == 0) check("busy_at_kick", int'(busy), 1);
          else        chk_rel = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr(logic [3:0] r);
    for (int i = 0; i < NREQ; i++) begin
      int jj = (ptr_m + i) % NREQ;
      if (r[jj]) return jj;
    end
    return 0;
  endfunction

  function automatic logic [15:0] nz();
    return 16'($urandom_range(1, 16'hFFFF));
  endfunction

  task automatic gen(int typ);
    int m;
    int n;
    int b;
    for (int i = 0; i < LEN; i++) L[i] = '0;
    case (typ)
      1: for (int i = 0; i < LEN; i++) L[i] = 16'h003F;
      2: ;
      3: begin
        b = MAXC - 1 + int'($urandom_range(0, 1));
        for (int i = 1; i <= b - QUIET; i++) L[i] = nz();
      end
      default: begin
        m = 1 + int'($urandom_range(0, 3));
        n = 3 + int'($urandom_range(0, 20));
        for (int c = 0; c < n; c++) begin
          L[m] = nz();
          m++;
          if ($urandom_range(0, 3) == 0 && c < n - 1) begin
            L[m] = '0;
            m++;
          end
        end
      end
    endcase
  endtask

  // current cycle must be an IDLE cycle of the DUT
  task automatic run_session(logic [3:0] r, int typ, bit drop);
    int k, m1, m2, run, e, idx;
    bit ab;
    ev_t ev;
    gen(typ);
    idx = rr(r);
    ptr_m = (idx + 1) % NREQ;
    req = r;
    k = cyc + 1;
    m1 = -1;
    for (int m = 1; m < LEN; m++)
      if (L[m] != 0) begin
        m1 = m;
        break;
      end
    m2 = -1;
    if (m1 > 0) begin
      run = 0;
      for (int m = m1 + 1; m < LEN; m++) begin
        if (L[m] == 0) run++;
        else           run = 0;
        if (run == QUIET) begin
          m2 = m;
          break;
        end
      end
    end
    if (m2 > 0 && m2 < MAXC) begin
      ab = 1'b0;
      e = k + m2 + 1;
    end else begin
      ab = 1'b1;
      e = k + MAXC + 1;
    end
    ev.kind = 0;
    ev.at = k;
    ev.g = 4'(1 << idx);
    exp_q.push_back(ev);
    ev.kind = ab ? 2 : 1;
    ev.at = e;
    exp_q.push_back(ev);
    tick();
    req = drop ? 4'd0 : 4'($urandom);
    LED = 16'($urandom);
    for (int m = 1; m <= e - k; m++) begin
      tick();
      LED = L[m];
      req = drop ? 4'd0 : 4'($urandom);
    end
    tick();
    req = '0;
    LED = '0;
  endtask

  initial begin
    ev_t ev;
    repeat (3) tick();
    check("rst_grant", int'(grant), 0);
    check("rst_flick", int'(flick), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_abort", int'(abort), 0);
    check("rst_flasher_rst_n", int'(flasher_rst_n), 0);
    reset = 1'b1;

    for (int s = 0; s < 3; s++) run_session(4'b1011, 0, 1'b0);
    run_session(4'b0010, 0, 1'b1);
    run_session(4'b0100, 1, 1'b0);
    run_session(4'b1000, 3, 1'b0);
    run_session(4'b0001, 2, 1'b0);

    for (int s = 0; s < 40; s++) begin
      int gap = int'($urandom_range(0, 2));
      int t = int'($urandom_range(0, 9));
      int typ = (t < 6) ? 0 : (t == 6 ? 1 : (t == 7 ? 2 : 3));
      logic [3:0] r = 4'($urandom_range(1, 15));
      repeat (gap) tick();
      run_session(r, typ, $urandom_range(0, 3) == 0);
    end

    req = 4'b0010;
    ev.kind = 0;
    ev.at = cyc + 1;
    ev.g = 4'(1 << rr(4'b0010));
    exp_q.push_back(ev);
    tick();
    LED = 16'h0001;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    check("midrst_grant", int'(grant), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_flick", int'(flick), 0);
    check("midrst_flasher_rst_n", int'(flasher_rst_n), 0);
    exp_q.delete();
    ptr_m = 0;
    req = '0;
    LED = '0;
    repeat (2) tick();
    reset = 1'b1;
    run_session(4'b1111, 0, 1'b0);
    run_session(4'b1111, 0, 1'b0);

    repeat (4) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
